// File: rtl/wordle_pkg.sv
// Shared constants and types for the Wordle board display path:
// default 640x480@60 VGA timing, default tile geometry and tile colour codes.
package wordle_pkg;

    // Default VGA timing, in 25 MHz pixel clocks (horizontal) and lines (vertical)
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Default tile geometry: 6 guess rows of 5 letters, 40 px tiles on a 48 px pitch
    localparam int DEF_TILE_X0    = 224;
    localparam int DEF_TILE_Y0    = 8;
    localparam int DEF_TILE_SIZE  = 40;
    localparam int DEF_TILE_PITCH = 48;
    localparam int DEF_NUM_ROWS   = 6;
    localparam int DEF_NUM_COLS   = 5;

    // Width of the beam position counters
    localparam int CNT_W = 10;

    // Tile colours as {R,G,B}
    typedef enum logic [2:0] {
        EMPTY  = 3'b000,
        GREEN  = 3'b010,
        YELLOW = 3'b110,
        WHITE  = 3'b111
    } color_e;

    // Per-pixel attributes carried alongside the colour-store read
    typedef struct packed {
        logic in_tile;
        logic edge_px;
        logic row_hit;
        logic h_sync;
        logic v_sync;
        logic visible;
    } s1_t;

endpackage

// File: rtl/wordle_grid_renderer_if.sv
// Read port of the guess-colour store: the renderer strobes an address,
// the store answers with the tile colour one board_clk later.
interface wordle_grid_renderer_if;
    import wordle_pkg::*;

    logic       rd_en;
    logic [4:0] rd_addr;
    logic [2:0] rd_data;

    modport master (output rd_en, output rd_addr, input  rd_data);
    modport slave  (input  rd_en, input  rd_addr, output rd_data);

endinterface

// File: rtl/wordle_vga_timing.sv
// VGA beam generator: divide-by-4 pixel enable, horizontal/vertical counters,
// raw (undelayed) sync and visible-area flags, and a frame-wrap strobe.
module wordle_vga_timing
    import wordle_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic             board_clk,
    input  logic             reset,
    output logic             o_pix_en,
    output logic [CNT_W-1:0] o_hcnt,
    output logic [CNT_W-1:0] o_vcnt,
    output logic             o_visible,
    output logic             o_h_sync,
    output logic             o_v_sync,
    output logic             o_frame_wrap
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    logic [1:0]       r_phase;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    logic             w_h_last;
    logic             w_v_last;

    assign o_pix_en = (r_phase == 2'd3);
    assign w_h_last = (r_hcnt == CNT_W'(H_TOTAL - 1));
    assign w_v_last = (r_vcnt == CNT_W'(V_TOTAL - 1));

    // Free-running phase counter: one pixel enable every fourth board_clk
    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) r_phase <= 2'd0;
        else       r_phase <= r_phase + 2'd1;
    end

    // Beam position: hcnt wraps per line, vcnt steps on each hcnt wrap
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (o_pix_en) begin
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? '0 : r_vcnt + CNT_W'(1);
            end else begin
                r_hcnt <= r_hcnt + CNT_W'(1);
            end
        end
    end

    assign o_hcnt       = r_hcnt;
    assign o_vcnt       = r_vcnt;
    assign o_visible    = (r_hcnt < CNT_W'(H_VISIBLE)) && (r_vcnt < CNT_W'(V_VISIBLE));
    assign o_h_sync     = !((r_hcnt >= CNT_W'(H_VISIBLE + H_FRONT)) &&
                            (r_hcnt <  CNT_W'(H_VISIBLE + H_FRONT + H_SYNC)));
    assign o_v_sync     = !((r_vcnt >= CNT_W'(V_VISIBLE + V_FRONT)) &&
                            (r_vcnt <  CNT_W'(V_VISIBLE + V_FRONT + V_SYNC)));
    assign o_frame_wrap = o_pix_en && w_h_last && w_v_last;

endmodule

// File: rtl/wordle_grid_renderer.sv
// Wordle board renderer: decodes the beam position into a tile, reads the
// tile colour from the game's colour store, outlines empty tiles of the
// active guess row and drives the VGA pins two pixel clocks after the beam.
module wordle_grid_renderer
    import wordle_pkg::*;
#(
    parameter int TILE_X0    = DEF_TILE_X0,
    parameter int TILE_Y0    = DEF_TILE_Y0,
    parameter int TILE_SIZE  = DEF_TILE_SIZE,
    parameter int TILE_PITCH = DEF_TILE_PITCH,
    parameter int NUM_ROWS   = DEF_NUM_ROWS,
    parameter int NUM_COLS   = DEF_NUM_COLS,
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK
) (
    input  logic                          board_clk,
    input  logic                          reset,
    wordle_grid_renderer_if.master        store_bus,
    input  logic [2:0]                    active_row,
    output logic                          vga_h_sync,
    output logic                          vga_v_sync,
    output logic                          vga_r,
    output logic                          vga_g,
    output logic                          vga_b,
    output logic                          frame_start
);

    logic             w_pix_en;
    logic [CNT_W-1:0] w_hcnt;
    logic [CNT_W-1:0] w_vcnt;
    logic             w_visible;
    logic             w_h_sync;
    logic             w_v_sync;
    logic             w_frame_wrap;

    wordle_vga_timing #(
        .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) u_timing (
        .board_clk    (board_clk),
        .reset        (reset),
        .o_pix_en     (w_pix_en),
        .o_hcnt       (w_hcnt),
        .o_vcnt       (w_vcnt),
        .o_visible    (w_visible),
        .o_h_sync     (w_h_sync),
        .o_v_sync     (w_v_sync),
        .o_frame_wrap (w_frame_wrap)
    );

    logic       w_col_hit, w_row_hit, w_x_edge, w_y_edge;
    logic [2:0] w_col, w_row;
    logic       w_in_tile;
    logic [4:0] w_addr;
    logic [2:0] w_rgb;

    logic       r_rd_en, r_rd_pend;
    logic [4:0] r_rd_addr;
    logic [2:0] r_hold;
    logic [2:0] r_latched_row;
    logic       r_frame_start;
    s1_t        r_s1;
    logic [2:0] r_rgb;
    logic       r_h_sync, r_v_sync;

    // S0: find the tile column/row under the beam and whether it is on the 2 px border
    // NOTE: every always_comb output is defaulted first so no latch can be inferred.
    always_comb begin
        w_col_hit = 1'b0;
        w_row_hit = 1'b0;
        w_x_edge  = 1'b0;
        w_y_edge  = 1'b0;
        w_col     = '0;
        w_row     = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (w_hcnt >= CNT_W'(TILE_X0 + TILE_PITCH*c) &&
                w_hcnt <= CNT_W'(TILE_X0 + TILE_PITCH*c + TILE_SIZE - 1)) begin
                w_col_hit = 1'b1;
                w_col     = 3'(c);
                w_x_edge  = (w_hcnt <= CNT_W'(TILE_X0 + TILE_PITCH*c + 1)) ||
                            (w_hcnt >= CNT_W'(TILE_X0 + TILE_PITCH*c + TILE_SIZE - 2));
            end
        end
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (w_vcnt >= CNT_W'(TILE_Y0 + TILE_PITCH*r) &&
                w_vcnt <= CNT_W'(TILE_Y0 + TILE_PITCH*r + TILE_SIZE - 1)) begin
                w_row_hit = 1'b1;
                w_row     = 3'(r);
                w_y_edge  = (w_vcnt <= CNT_W'(TILE_Y0 + TILE_PITCH*r + 1)) ||
                            (w_vcnt >= CNT_W'(TILE_Y0 + TILE_PITCH*r + TILE_SIZE - 2));
            end
        end
    end

    assign w_in_tile = w_col_hit && w_row_hit && w_visible;
    assign w_addr    = 5'(w_row) * 5'(NUM_COLS) + 5'(w_col);

    // S1: one-cycle read strobe for tile pixels; address holds between tiles
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_rd_en <= w_pix_en && w_in_tile;
            if (w_pix_en && w_in_tile) r_rd_addr <= w_addr;
        end
    end

    // S1: pixel attributes travel next to the outstanding read
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '{in_tile: 1'b0, edge_px: 1'b0, row_hit: 1'b0,
                      h_sync: 1'b1, v_sync: 1'b1, visible: 1'b0};
        end else if (w_pix_en) begin
            r_s1 <= '{in_tile: w_in_tile, edge_px: w_x_edge || w_y_edge,
                      row_hit: (w_row == r_latched_row),
                      h_sync: w_h_sync, v_sync: w_v_sync, visible: w_visible};
        end
    end

    // Capture the store's answer on the cycle after the strobe
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_rd_pend <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_rd_pend <= r_rd_en;
            if (r_rd_pend) r_hold <= store_bus.rd_data;
        end
    end

    // Frame boundary: pulse frame_start and freeze the highlighted row for the whole frame
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_frame_start <= 1'b0;
            r_latched_row <= 3'd7;
        end else begin
            r_frame_start <= w_frame_wrap;
            if (w_frame_wrap) r_latched_row <= active_row;
        end
    end

    // S2 colour select: blanking, then empty-tile outline, then stored colour
    always_comb begin
        w_rgb = EMPTY;
        if (!r_s1.visible)                                                     w_rgb = EMPTY;
        else if (r_s1.in_tile && r_s1.edge_px && r_s1.row_hit && r_hold == EMPTY) w_rgb = WHITE;
        else if (r_s1.in_tile)                                                 w_rgb = r_hold;
    end

    // S2: register colour and the twice-delayed syncs so they reach the pins together
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_rgb    <= '0;
            r_h_sync <= 1'b1;
            r_v_sync <= 1'b1;
        end else if (w_pix_en) begin
            r_rgb    <= w_rgb;
            r_h_sync <= r_s1.h_sync;
            r_v_sync <= r_s1.v_sync;
        end
    end

    assign store_bus.rd_en   = r_rd_en;
    assign store_bus.rd_addr = r_rd_addr;
    assign vga_r             = r_rgb[2];
    assign vga_g             = r_rgb[1];
    assign vga_b             = r_rgb[0];
    assign vga_h_sync        = r_h_sync;
    assign vga_v_sync        = r_v_sync;
    assign frame_start       = r_frame_start;

endmodule

// File: tb/tb_wordle_grid_renderer.sv
// Bench for wordle_grid_renderer on a shrunken raster (64x56 totals, 6 px tiles
// on an 8 px pitch) so several whole frames fit in a short run. Pixel n of a
// frame (n = y*64 + x) is held by the counters in cycles 4n..4n+3 after reset
// release, its read strobe appears in cycle 4n+4 and its pins in 4n+8..4n+11.
module tb_wordle_grid_renderer;
    import wordle_pkg::*;

    localparam int HT   = 64;          // 48 visible + 4 front + 8 sync + 4 back
    localparam int VT   = 56;          // 50 visible + 2 front + 2 sync + 2 back
    localparam int FR   = HT * VT * 4; // board_clk cycles per frame
    localparam int POST = 100;         // frame tag for vectors after the mid-frame reset

    logic       board_clk = 1'b0;
    logic       reset     = 1'b1;
    logic [2:0] active_row = 3'd7;
    logic       vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b, frame_start;

    wordle_grid_renderer_if store_bus ();

    wordle_grid_renderer #(
        .TILE_X0(4), .TILE_Y0(2), .TILE_SIZE(6), .TILE_PITCH(8),
        .NUM_ROWS(6), .NUM_COLS(5),
        .H_VISIBLE(48), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(50), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) dut (
        .board_clk   (board_clk),
        .reset       (reset),
        .store_bus   (store_bus),
        .active_row  (active_row),
        .vga_h_sync  (vga_h_sync),
        .vga_v_sync  (vga_v_sync),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_start (frame_start)
    );

    always #5 board_clk = ~board_clk;

    // Colour store model: synchronous read, data one board_clk after the strobe
    logic [2:0] mem [32];
    always @(posedge board_clk) begin
        if (reset)                store_bus.rd_data <= 3'b000;
        else if (store_bus.rd_en) store_bus.rd_data <= mem[store_bus.rd_addr];
    end

    // Cycle index since the last reset release
    int cyc;
    always @(posedge board_clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int n_vec = 0;
    int n_err = 0;
    int n_fs  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge board_clk);
    endtask

    typedef struct {
        int f, x, y;
        logic [2:0] rgb;
        logic hs, vs;
        int rd;        // -1 no read check, 0 no strobe expected, 1 strobe expected
        logic [4:0] addr;
        int set_row;   // -1 leave active_row alone
    } vec_t;

    typedef struct { int due, f, x, y; logic [2:0] rgb; logic hs, vs; } pix_exp_t;
    typedef struct { int due, f, x, y; logic rd; logic [4:0] addr; } rd_exp_t;

    vec_t     vecs[$];
    pix_exp_t pix_q[$];
    rd_exp_t  rd_q[$];

    function automatic void add(input int f, input int x, input int y, input logic [2:0] rgb,
                                input logic hs, input logic vs, input int rd,
                                input logic [4:0] addr, input int set_row);
        vec_t v;
        v.f = f; v.x = x; v.y = y; v.rgb = rgb; v.hs = hs; v.vs = vs;
        v.rd = rd; v.addr = addr; v.set_row = set_row;
        vecs.push_back(v);
    endfunction

    // Pin monitor: compares colour and syncs when a scheduled pixel is on the pins
    initial begin
        pix_exp_t pe;
        forever begin
            @(negedge board_clk);
            while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
                pe = pix_q.pop_front();
                check($sformatf("pins f%0d (%0d,%0d) {rgb,hs,vs} at cycle %0d/%0d",
                                pe.f, pe.x, pe.y, cyc, pe.due),
                      {27'd0, vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync},
                      {27'd0, pe.rgb, pe.hs, pe.vs});
            end
        end
    end

    // Read monitor: compares strobe and address in the cycle after the pixel's enable
    initial begin
        rd_exp_t re;
        forever begin
            @(negedge board_clk);
            while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
                re = rd_q.pop_front();
                check($sformatf("read f%0d (%0d,%0d) rd_en at cycle %0d/%0d",
                                re.f, re.x, re.y, cyc, re.due),
                      {31'd0, store_bus.rd_en}, {31'd0, re.rd});
                if (re.rd)
                    check($sformatf("read f%0d (%0d,%0d) rd_addr", re.f, re.x, re.y),
                          {27'd0, store_bus.rd_addr}, {27'd0, re.addr});
            end
        end
    end

    // Frame-start monitor: each pulse must land exactly one frame after the previous one
    initial begin : fs_mon
        int exp_fs;
        exp_fs = FR;
        forever begin
            @(negedge board_clk);
            if (reset) exp_fs = FR;
            else if (frame_start) begin
                check("frame_start cycle", cyc, exp_fs);
                exp_fs += FR;
                n_fs++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_values(input string tag);
        check({tag, " rd_en"},       {31'd0, store_bus.rd_en}, 32'd0);
        check({tag, " rd_addr"},     {27'd0, store_bus.rd_addr}, 32'd0);
        check({tag, " hsync"},       {31'd0, vga_h_sync}, 32'd1);
        check({tag, " vsync"},       {31'd0, vga_v_sync}, 32'd1);
        check({tag, " rgb"},         {29'd0, vga_r, vga_g, vga_b}, 32'd0);
        check({tag, " frame_start"}, {31'd0, frame_start}, 32'd0);
    endtask

    initial begin
        int t, base;
        bit did_rst;
        did_rst = 1'b0;

        for (int i = 0; i < 32; i++) mem[i] = EMPTY;
        for (int i = 0; i < 5; i++) mem[i] = GREEN;        // row 0 green
        for (int i = 10; i < 15; i++) mem[i] = GREEN;      // row 2 green ...
        mem[13] = YELLOW;                                  // ... except col 3
        mem[22] = GREEN;                                   // row 4 col 2
        mem[25] = 3'b101;                                  // row 5 col 0

        // Frame 0: highlight from reset is row 7 (none)
        add(0,  0,  0, 3'b000, 1, 1, -1,  0, -1);
        add(0,  0,  1, 3'b000, 1, 1, -1,  0,  1);
        add(0,  4,  2, 3'b010, 1, 1,  1,  0, -1);
        add(0, 10,  2, 3'b000, 1, 1,  0,  0, -1);
        add(0, 51,  5, 3'b000, 1, 1,  0,  0, -1);
        add(0, 52,  5, 3'b000, 0, 1,  0,  0, -1);
        add(0, 59,  5, 3'b000, 0, 1, -1,  0, -1);
        add(0, 60,  5, 3'b000, 1, 1, -1,  0, -1);
        add(0, 12, 10, 3'b000, 1, 1,  1,  6, -1);
        add(0, 29, 19, 3'b110, 1, 1,  1, 13, -1);
        add(0, 36, 19, 3'b010, 1, 1,  1, 14, -1);
        add(0, 31, 21, 3'b110, 1, 1,  1, 13, -1);
        add(0,  0, 51, 3'b000, 1, 1, -1,  0, -1);
        add(0, 20, 52, 3'b000, 1, 0,  0,  0, -1);
        add(0,  0, 53, 3'b000, 1, 0, -1,  0, -1);
        add(0,  0, 54, 3'b000, 1, 1, -1,  0, -1);
        // Frame 1: row 1 latched; active_row moves to 4 before row 1 is drawn
        add(1,  0,  5, 3'b000, 1, 1, -1,  0,  4);
        add(1, 12, 10, 3'b111, 1, 1,  1,  6, -1);
        add(1, 13, 11, 3'b111, 1, 1, -1,  0, -1);
        add(1, 14, 12, 3'b000, 1, 1, -1,  0, -1);
        add(1, 17, 13, 3'b111, 1, 1, -1,  0, -1);
        add(1, 15, 15, 3'b111, 1, 1, -1,  0, -1);
        add(1, 12, 34, 3'b000, 1, 1,  1, 21, -1);
        // Frame 2: row 4 latched
        add(2, 12, 10, 3'b000, 1, 1, -1,  0, -1);
        add(2,  4, 34, 3'b111, 1, 1,  1, 20, -1);
        add(2, 12, 34, 3'b111, 1, 1, -1,  0, -1);
        add(2, 20, 34, 3'b010, 1, 1,  1, 22, -1);
        add(2, 14, 36, 3'b000, 1, 1, -1,  0, -1);
        add(2,  4, 42, 3'b101, 1, 1,  1, 25, -1);
        // Frame 3: in horizontal sync just before the reset at (56,25)
        add(3, 53, 25, 3'b000, 0, 1,  0,  0, -1);
        // After the mid-frame reset: timing restarts at (0,0), no highlight
        add(POST,  0,  0, 3'b000, 1, 1, -1,  0, -1);
        add(POST,  4,  2, 3'b010, 1, 1,  1,  0, -1);
        add(POST, 12, 34, 3'b000, 1, 1,  1, 21, -1);

        repeat (3) @(negedge board_clk);
        check_reset_values("power-on reset");
        reset = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].f == POST && !did_rst) begin
                wait_cyc(3*FR + 4*(25*HT + 56));
                #1 reset = 1'b1;
                #1;
                check_reset_values("mid-frame reset");
                check("frame_start pulses before reset", n_fs, 3);
                repeat (5) @(negedge board_clk);
                reset = 1'b0;
                did_rst = 1'b1;
            end
            base = (vecs[i].f == POST) ? 0 : vecs[i].f * FR;
            t = base + 4*(vecs[i].y*HT + vecs[i].x);
            wait_cyc(t);
            if (vecs[i].set_row >= 0) active_row = 3'(vecs[i].set_row);
            pix_q.push_back('{due: t + 9, f: vecs[i].f, x: vecs[i].x, y: vecs[i].y,
                              rgb: vecs[i].rgb, hs: vecs[i].hs, vs: vecs[i].vs});
            if (vecs[i].rd >= 0)
                rd_q.push_back('{due: t + 4, f: vecs[i].f, x: vecs[i].x, y: vecs[i].y,
                                 rd: (vecs[i].rd == 1), addr: vecs[i].addr});
        end

        repeat (16) @(negedge board_clk);
        check("pin expectations left unchecked", pix_q.size(), 0);
        check("read expectations left unchecked", rd_q.size(), 0);
        check("frame_start pulses after restart", n_fs, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
